// File: rtl/dmem_responder.sv
// dmem_responder: load/store end-point for the core's data port, backed by a
// word-organised SRAM of 2^ADDR_W 32-bit words.
// Optional feature macro: DMEM_WAIT_EN inserts WAIT_CYCLES wait states per
// access (WAIT state, down-counter and busy). Without it every access
// completes in one cycle and busy is tied low.
module dmem_responder #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        request,
   input  logic        load,
   input  logic        store,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  mask,
   output logic [31:0] rdata,
   output logic        valid,
   output logic        busy,
   output logic        err
);

   localparam int unsigned Depth = 1 << ADDR_W;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic              accept;
   logic              do_access;
   logic              acc_load, acc_store, acc_illegal;
   logic [31:0]       acc_addr, acc_wdata;
   logic [3:0]        acc_mask;
   logic [ADDR_W-1:0] acc_idx;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [31:0]       mem [Depth];

   // Requests are dropped while an access is waiting.
   assign accept = request && (state_q != StWait);

`ifdef DMEM_WAIT_EN
   logic [3:0]  cnt_q, cnt_d;
   logic        hold_load_q, hold_store_q;
   logic [31:0] hold_addr_q, hold_wdata_q;
   logic [3:0]  hold_mask_q;

   // Holding registers and wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q        <= 4'd0;
         hold_load_q  <= 1'b0;
         hold_store_q <= 1'b0;
         hold_addr_q  <= 32'h0;
         hold_wdata_q <= 32'h0;
         hold_mask_q  <= 4'h0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            hold_load_q  <= load;
            hold_store_q <= store;
            hold_addr_q  <= addr;
            hold_wdata_q <= wdata;
            hold_mask_q  <= mask;
         end
      end
   end

   // Counter loads WAIT_CYCLES-1 on entry to WAIT and counts down to 0.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && (WAIT_CYCLES > 0)) begin
         cnt_d = 4'(WAIT_CYCLES - 1);
      end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // In WAIT the access comes from the holding registers, otherwise straight
   // from the port (zero-wait accesses complete on the accepting edge).
   always_comb begin
      if (state_q == StWait) begin
         acc_load  = hold_load_q;
         acc_store = hold_store_q;
         acc_addr  = hold_addr_q;
         acc_wdata = hold_wdata_q;
         acc_mask  = hold_mask_q;
      end else begin
         acc_load  = load;
         acc_store = store;
         acc_addr  = addr;
         acc_wdata = wdata;
         acc_mask  = mask;
      end
   end
`else
   // Without wait states every access is performed on the accepting edge.
   always_comb begin
      acc_load  = load;
      acc_store = store;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_mask  = mask;
   end
`endif

   assign acc_idx     = acc_addr[ADDR_W+1:2];
   assign acc_illegal = ((acc_addr >> (ADDR_W + 2)) != 32'h0)
                        || (acc_load && acc_store)
                        || (acc_store && (acc_mask == 4'h0));

   // The array access happens on the edge that enters RESP.
   assign do_access = (state_d == StResp);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StResp: begin
            if (request) begin
`ifdef DMEM_WAIT_EN
               state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
`else
               state_d = StResp;
`endif
            end else begin
               state_d = StIdle;
            end
         end
`ifdef DMEM_WAIT_EN
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      valid = (state_q == StResp);
`ifdef DMEM_WAIT_EN
      busy  = (state_q == StWait);
`else
      busy  = 1'b0;
`endif
      rdata = rdata_q;
      err   = err_q;
   end

   // Read data and error flag; err only ever accompanies a valid cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else if (do_access) begin
         err_q <= acc_illegal;
         if (acc_illegal) begin
            rdata_q <= 32'h0;
         end else if (acc_load) begin
            rdata_q <= mem[acc_idx];
         end
      end else begin
         err_q <= 1'b0;
      end
   end

   // Byte-lane array write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_access && acc_store && !acc_illegal) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_mask[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
